ltc2308_spi_ctrl: RTL and testbench

- Conversion/SPI engine for the LTC2308 8-channel 12-bit ADC.
- Sits directly downstream of the ADC FIFO controller. On each start request it pulses CONVST, waits out the conversion, then runs one 12-bit SPI frame. The frame shifts the next channel's 6-bit config word out on SDI and captures the result from SDO.
- Returns the 12-bit result with a level "done" flag that the FIFO controller edge-detects for its write request.
- LTC2308 pipelining applies: the config sent in frame N selects the channel for conversion N+1. The upstream discards the first result.

---
 rtl/ltc2308_spi_ctrl.sv | 143 ++++++++++++++
 tb/tb_ltc2308_spi_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ltc2308_spi_ctrl.sv
// LTC2308 conversion and SPI frame engine: CONVST pulse, conversion wait,
// then one 12-bit frame shifting the next config out and the result in.
module ltc2308_spi_ctrl #(
  parameter int CLK_DIV       = 2,
  parameter int CONVST_CYCLES = 2,
  parameter int CONV_CYCLES   = 64,
  parameter bit UNIPOLAR      = 1'b1,
  parameter bit SLEEP         = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        measure_start,
  input  logic [2:0]  measure_ch,
  output logic        measure_done,
  output logic [11:0] measure_dataread,
  output logic        ADC_CONVST,
  output logic        ADC_SCK,
  output logic        ADC_SDI,
  input  logic        ADC_SDO
);

  localparam int MAX_A = (CLK_DIV > CONVST_CYCLES) ? CLK_DIV : CONVST_CYCLES;
  localparam int MAX_N = (MAX_A > CONV_CYCLES) ? MAX_A : CONV_CYCLES;
  localparam int CW    = $clog2(MAX_N + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVST,
    S_CONV_WAIT,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_idx;
  logic [2:0]    r_ch;
  logic [11:0]   r_shift;
  logic [11:0]   r_data;
  logic          r_start_prev;
  logic          r_convst;
  logic          r_sck;
  logic          r_sdi;
  logic          r_done;

  logic          w_start_edge;
  logic [11:0]   w_tx;
  logic [3:0]    w_idx_nxt;

  assign w_start_edge = measure_start & ~r_start_prev;
  assign w_idx_nxt    = r_idx - 4'd1;

  // Frame-wide SDI pattern indexed by bit position: config in 11..6, zeros below.
  assign w_tx = {1'b1, r_ch[0], r_ch[2], r_ch[1], UNIPOLAR, SLEEP, 6'b0};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_ch         <= '0;
      r_shift      <= '0;
      r_data       <= '0;
      r_start_prev <= 1'b0;
      r_convst     <= 1'b0;
      r_sck        <= 1'b0;
      r_sdi        <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_start_prev <= measure_start;
      unique case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_ch     <= measure_ch;
            r_done   <= 1'b0;
            r_convst <= 1'b1;
            r_cnt    <= CW'(CONVST_CYCLES - 1);
            r_state  <= S_CONVST;
          end
        end
        S_CONVST: begin
          if (r_cnt == '0) begin
            r_convst <= 1'b0;
            r_cnt    <= CW'(CONV_CYCLES - 1);
            r_state  <= S_CONV_WAIT;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_CONV_WAIT: begin
          if (r_cnt == '0) begin
            r_sdi   <= w_tx[11];
            r_idx   <= 4'd11;
            r_cnt   <= CW'(CLK_DIV - 1);
            r_state <= S_SHIFT_LO;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_SHIFT_LO: begin
          if (r_cnt == '0) begin
            r_sck          <= 1'b1;
            r_shift[r_idx] <= ADC_SDO;
            r_cnt          <= CW'(CLK_DIV - 1);
            r_state        <= S_SHIFT_HI;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_SHIFT_HI: begin
          if (r_cnt == '0) begin
            r_sck <= 1'b0;
            r_cnt <= CW'(CLK_DIV - 1);
            if (r_idx != 4'd0) begin
              r_idx   <= w_idx_nxt;
              r_sdi   <= w_tx[w_idx_nxt];
              r_state <= S_SHIFT_LO;
            end else begin
              r_state <= S_DONE;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DONE: begin
          r_data  <= r_shift;
          r_done  <= 1'b1;
          r_sdi   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign measure_done     = r_done;
  assign measure_dataread = r_data;
  assign ADC_CONVST       = r_convst;
  assign ADC_SCK          = r_sck;
  assign ADC_SDI          = r_sdi;

endmodule

// File: tb/tb_ltc2308_spi_ctrl.sv
// Bench for ltc2308_spi_ctrl: default-timing and fastest-timing instances
// driven by a behavioural LTC2308 SDO model and a frame monitor.
module tb_ltc2308_spi_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic             rst;
  logic [1:0]       start;
  logic [1:0][2:0]  ch;
  logic [1:0]       done;
  logic [1:0][11:0] dout;
  logic [1:0]       convst;
  logic [1:0]       sck;
  logic [1:0]       sdi;
  logic [1:0]       sdo;

  logic [11:0] sdo_val [2];

  int npass = 0;
  int ntot  = 0;

  // monitor state, written only by the monitor process
  logic [1:0]  p_sck, p_sdi, p_convst, p_done;
  int          cyc [2], cw [2], rises [2], falls [2], bad [2], stab [2];
  int          first_r [2], last_r [2], done_cyc [2], n_cv [2], n_dn [2];
  logic [11:0] sdi_bits [2];

  ltc2308_spi_ctrl #(
    .CLK_DIV(2), .CONVST_CYCLES(2), .CONV_CYCLES(64),
    .UNIPOLAR(1'b1), .SLEEP(1'b0)
  ) u_def (
    .clock(clock), .reset(rst),
    .measure_start(start[0]), .measure_ch(ch[0]),
    .measure_done(done[0]), .measure_dataread(dout[0]),
    .ADC_CONVST(convst[0]), .ADC_SCK(sck[0]),
    .ADC_SDI(sdi[0]), .ADC_SDO(sdo[0])
  );

  ltc2308_spi_ctrl #(
    .CLK_DIV(1), .CONVST_CYCLES(1), .CONV_CYCLES(1),
    .UNIPOLAR(1'b1), .SLEEP(1'b0)
  ) u_fast (
    .clock(clock), .reset(rst),
    .measure_start(start[1]), .measure_ch(ch[1]),
    .measure_done(done[1]), .measure_dataread(dout[1]),
    .ADC_CONVST(convst[1]), .ADC_SCK(sck[1]),
    .ADC_SDI(sdi[1]), .ADC_SDO(sdo[1])
  );

  function automatic int div(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic int cvc(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic int cwc(input int d);
    return (d == 0) ? 64 : 1;
  endfunction

  function automatic int lat(input int d);
    return cvc(d) + cwc(d) + 24 * div(d) + 1;
  endfunction

  // Single-ended config word: SD, OS=ch0, S1=ch2, S0=ch1, UNI=1, SLP=0
  function automatic logic [5:0] cfg_of(input logic [2:0] c);
    return {1'b1, c[0], c[2], c[1], 1'b1, 1'b0};
  endfunction

  // ADC model: MSB ready before the first rise, next bit after each SCK fall
  function automatic logic sdo_bit(input logic [11:0] v, input int f);
    logic [11:0] s;
    s = v << f;
    return s[11];
  endfunction

  assign sdo[0] = sdo_bit(sdo_val[0], falls[0]);
  assign sdo[1] = sdo_bit(sdo_val[1], falls[1]);

  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      p_sck[d]    <= sck[d];
      p_sdi[d]    <= sdi[d];
      p_convst[d] <= convst[d];
      p_done[d]   <= done[d];
      if (convst[d] && !p_convst[d]) begin
        n_cv[d]     <= n_cv[d] + 1;
        cyc[d]      <= 0;
        cw[d]       <= 1;
        rises[d]    <= 0;
        falls[d]    <= 0;
        bad[d]      <= 0;
        stab[d]     <= 0;
        first_r[d]  <= 0;
        last_r[d]   <= 0;
        done_cyc[d] <= 0;
        sdi_bits[d] <= '0;
      end else begin
        cyc[d]  <= cyc[d] + 1;
        stab[d] <= (sdi[d] != p_sdi[d]) ? 0 : stab[d] + 1;
        if (convst[d])
          cw[d] <= cw[d] + 1;
        bad[d] <= bad[d]
          + int'(sdi[d] != p_sdi[d] && sck[d] && p_sck[d])
          + int'(sck[d] && !p_sck[d] &&
                 ((sdi[d] != p_sdi[d]) ? 0 : stab[d] + 1) < div(d));
        if (sck[d] && !p_sck[d]) begin
          rises[d]    <= rises[d] + 1;
          last_r[d]   <= cyc[d] + 1;
          sdi_bits[d] <= {sdi_bits[d][10:0], sdi[d]};
          if (rises[d] == 0)
            first_r[d] <= cyc[d] + 1;
        end
        if (!sck[d] && p_sck[d])
          falls[d] <= falls[d] + 1;
        if (done[d] && !p_done[d]) begin
          n_dn[d]     <= n_dn[d] + 1;
          done_cyc[d] <= cyc[d] + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input int d,
                     input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp)
      npass++;
    else
      $display("FAIL %s[dut%0d]: got %0h expected %0h", nm, d, act, exp);
  endtask

  // One full frame; called at a negedge, returns at a negedge.
  task automatic frame(input int d, input logic [2:0] c,
                       input logic [11:0] v, input logic [5:0] xcfg);
    int t;
    sdo_val[d] = v;
    ch[d]      = c;
    start[d]   = 1'b1;
    @(negedge clock);
    chk("convst_up_done_low", d, {30'd0, convst[d], done[d]}, 32'd2);
    start[d] = 1'b0;
    ch[d]    = ~c;
    t = 0;
    while (!done[d] && t < 400) begin
      @(negedge clock);
      t++;
    end
    #1;
    chk("done_seen", d, done[d], 1);
    chk("latency", d, done_cyc[d], lat(d));
    chk("convst_width", d, cw[d], cvc(d));
    chk("sck_rises", d, rises[d], 12);
    chk("sck_span", d, last_r[d] - first_r[d], 22 * div(d));
    chk("sdi_bits", d, sdi_bits[d], {xcfg, 6'b0});
    chk("sdi_timing", d, bad[d], 0);
    chk("dataread", d, dout[d], v);
    @(negedge clock);
  endtask

  typedef struct {
    int         d;
    logic [2:0] c;
    logic [11:0] v;
    logic [5:0] cfg;
  } vec_t;

  vec_t vt [8];

  initial begin
    int t, b_cv, b_dn;
    logic [2:0] rc;
    logic [11:0] rv;
    int rd;

    vt[0] = '{0, 3'd5, 12'hA5C, 6'b111010};
    vt[1] = '{0, 3'd0, 12'h000, 6'b100010};
    vt[2] = '{0, 3'd7, 12'hFFF, 6'b111110};
    vt[3] = '{0, 3'd2, 12'h800, 6'b100110};
    vt[4] = '{1, 3'd5, 12'hA5C, 6'b111010};
    vt[5] = '{1, 3'd3, 12'h123, 6'b110110};
    vt[6] = '{1, 3'd4, 12'hFED, 6'b101010};
    vt[7] = '{0, 3'd1, 12'h7E1, 6'b110010};

    rst        = 1'b1;
    start      = '0;
    ch         = '0;
    sdo_val[0] = '0;
    sdo_val[1] = '0;
    repeat (3) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      chk("reset_ctl", d, {28'd0, convst[d], sck[d], sdi[d], done[d]}, 0);
      chk("reset_data", d, dout[d], 0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 8; i++)
      frame(vt[i].d, vt[i].c, vt[i].v, vt[i].cfg);

    // second edge inside CONV_WAIT, then start held high 300 cycles
    b_cv = n_cv[0];
    b_dn = n_dn[0];
    sdo_val[0] = 12'h5A3;
    ch[0]      = 3'd3;
    start[0]   = 1'b1;
    @(negedge clock);
    start[0] = 1'b0;
    repeat (20) @(negedge clock);
    start[0] = 1'b1;
    repeat (300) @(negedge clock);
    start[0] = 1'b0;
    repeat (5) @(negedge clock);
    #1;
    chk("hold_convst_count", 0, n_cv[0] - b_cv, 1);
    chk("hold_done_count", 0, n_dn[0] - b_dn, 1);
    chk("hold_data", 0, dout[0], 12'h5A3);
    chk("hold_done", 0, done[0], 1);
    @(negedge clock);

    // reset in the middle of the shift phase
    sdo_val[0] = 12'h3C6;
    ch[0]      = 3'd4;
    start[0]   = 1'b1;
    @(negedge clock);
    start[0] = 1'b0;
    t = 0;
    while (rises[0] < 5 && t < 400) begin
      @(negedge clock);
      t++;
    end
    chk("mid_reached", 0, int'(rises[0] >= 5), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_reset_ctl", 0, {28'd0, convst[0], sck[0], sdi[0], done[0]}, 0);
    chk("mid_reset_data", 0, dout[0], 0);
    @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    frame(0, 3'd6, 12'h3C6, cfg_of(3'd6));

    // done is a level that persists until the next accepted start
    repeat (50) @(negedge clock);
    chk("done_persist", 0, done[0], 1);
    chk("data_persist", 0, dout[0], 12'h3C6);
    frame(0, 3'd2, 12'h9B4, cfg_of(3'd2));

    for (int i = 0; i < 6; i++) begin
      rd = int'($urandom_range(0, 1));
      rc = 3'($urandom_range(0, 7));
      rv = 12'($urandom);
      frame(rd, rc, rv, cfg_of(rc));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
